// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that lets NREQ producers share a single
//   synchronous FIFO write port. Ownership is granted to one producer at a
//   time for a burst of up to BURST_LEN accepted words. Ownership then
//   rotates, with one idle cycle between consecutive grants.
//
// Optional build macro: FIFO_ARB_PRIO_EN
//   When defined, requester 0 is high priority. It wins every idle-cycle
//   selection. Releasing a grant held by requester 0 leaves the round-robin
//   pointer where it was.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous, active-low reset
//   req        in   [NREQ]     req[i]: producer i presents a valid word
//   req_data   in   [NREQ*DW]  producer i word at [i*DW +: DW]
//   fifo_full  in   FIFO full flag
//   gnt        out  [NREQ]     registered one-hot grant, zero when idle
//   ack        out  [NREQ]     word of producer i written this cycle
//   fifo_wr    out  write strobe to the FIFO
//   fifo_data  out  [DW]       owner's word while busy, else zero
//   busy       out  high while a producer owns the port
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               fifo_full,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_data,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  localparam logic [3:0]    LAST_CNT = 4'(BURST_LEN - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [0:0]      r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [3:0]      r_burst_cnt;
  logic [NREQ-1:0] r_gnt;

  logic            w_busy;
  logic            w_owner_req;
  logic            w_accept;
  logic            w_last;
  logic            w_release;
  logic [PW-1:0]   w_owner_inc;
  logic [PW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_onehot;

  assign w_busy      = (r_state == S_OWN);
  assign w_owner_req = req[r_owner];
  assign w_accept    = w_busy & w_owner_req & ~fifo_full;
  assign w_last      = w_accept && (r_burst_cnt == LAST_CNT);
  // An owner that stops requesting gives up the port immediately.
  assign w_release   = w_busy && (w_last || !w_owner_req);
  assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  // Search upward from the round-robin pointer. The first hit wins.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req[0]) w_sel = '0;
`endif
    w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_gnt       <= '0;
    end else if (r_state == S_IDLE) begin
      if (|req) begin
        r_state     <= S_OWN;
        r_owner     <= w_sel;
        r_gnt       <= w_sel_onehot;
        r_burst_cnt <= '0;
      end
    end else begin
      if (w_release) begin
        r_state     <= S_IDLE;
        r_gnt       <= '0;
        r_burst_cnt <= '0;
`ifdef FIFO_ARB_PRIO_EN
        // A priority grant must not disturb the rotation among the others.
        if (r_owner != '0) r_rr_ptr <= w_owner_inc;
`else
        r_rr_ptr    <= w_owner_inc;
`endif
      end else if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
    end
  end

  // r_gnt is one-hot on the owner while busy, so it doubles as the ack mask.
  assign gnt       = r_gnt;
  assign busy      = w_busy;
  assign fifo_wr   = w_accept;
  assign ack       = w_accept ? r_gnt : '0;
  assign fifo_data = w_busy ? req_data[r_owner*DW +: DW] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_full;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_data;
  logic               busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .gnt(gnt), .ack(ack), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where rotation resumes, words so far.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_words;

  logic [NREQ-1:0] e_gnt, e_ack;
  logic            e_wr, e_busy;
  logic [DW-1:0]   e_data;

  // Producers: each holds a queue of pending words; mask forces req low.
  logic [DW-1:0] pq [NREQ][$];
  bit            mask [NREQ];
  int            wcount;
  logic [DW-1:0] wlog [$];

  function automatic logic [17:0] obs_vec();
    return {gnt, ack, fifo_wr, fifo_data, busy};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {e_gnt, e_ack, e_wr, e_data, e_busy};
  endfunction

  function automatic int gnt_idx();
    for (int i = 0; i < NREQ; i++) if (gnt[i]) return i;
    return -1;
  endfunction

  function automatic int pick();
`ifdef FIFO_ARB_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = mask[i] && (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : DW'($urandom);
    end
  endtask

  // Let inputs settle, then compute what the outputs must be this cycle.
  task automatic settle();
    bit acc;
    #1;
    acc    = m_busy && req[m_owner] && !fifo_full;
    e_busy = m_busy;
    e_gnt  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e_wr   = acc;
    e_ack  = acc ? e_gnt : 4'b0000;
    e_data = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_wr) begin
      wlog.push_back(e_data);
      wcount++;
      void'(pq[m_owner].pop_front());
    end
    if (!m_busy) begin
      if (req != 0) begin
        m_owner = pick();
        m_busy  = 1'b1;
        m_words = 0;
      end
    end else begin
      if (e_wr) m_words++;
      if ((e_wr && m_words == BL) || !req[m_owner]) begin
        m_busy  = 1'b0;
        m_words = 0;
`ifdef FIFO_ARB_PRIO_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % NREQ;
`else
        m_ptr = (m_owner + 1) % NREQ;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_words = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pq[i].delete();
      mask[i] = 1'b1;
    end
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pq[i].delete();
      pq[i].push_back(8'h10 + 8'(i));
      mask[i] = 1'b1;
    end
    model_reset();
    drive();
    for (int c = 0; c < 3; c++) begin
      #1;
      if (obs_vec() !== 18'h0) begin
        errors++;
        $display("FAIL reset_state c=%0d got %h expected 00000", c, obs_vec());
      end
      checks++;
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    wcount = 0;
    wlog.delete();
    for (int w = 0; w < 6; w++) pq[1].push_back(8'hA1 + 8'(w));
    for (int c = 0; c < 9; c++) begin
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if ((c == 1 || c == 4 || c == 6) && gnt !== 4'b0010) begin
        errors++;
        $display("FAIL single_gnt c=%0d got %b expected 0010", c, gnt);
      end
      if (c == 5 && (gnt !== 4'b0000 || fifo_wr !== 1'b0)) begin
        errors++;
        $display("FAIL single_idle c=%0d got gnt=%b wr=%b expected 0000/0", c, gnt, fifo_wr);
      end
      checks++;
      tick();
    end
    for (int w = 0; w < 6; w++) begin
      if (w >= wlog.size() || wlog[w] !== 8'hA1 + 8'(w)) begin
        errors++;
        $display("FAIL single_data word=%0d got %h expected %h", w,
                 (w < wlog.size()) ? wlog[w] : 8'hxx, 8'hA1 + 8'(w));
      end
      checks++;
    end
  endtask

  task automatic test_contend();
    int order [$];
    int prev;
    do_reset();
    wcount = 0;
    prev = -1;
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < 8; w++) pq[i].push_back(8'(i * 16 + w));
    for (int c = 0; c < 22; c++) begin
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL contend c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (gnt_idx() >= 0 && prev < 0) order.push_back(gnt_idx());
      prev = gnt_idx();
      if (c == 19) begin
        if (wcount + int'(fifo_wr) !== 16) begin
          errors++;
          $display("FAIL contend_count got %0d expected 16", wcount + int'(fifo_wr));
        end
        checks++;
      end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      if (k >= order.size() || order[k] !== (k % NREQ)) begin
        errors++;
        $display("FAIL contend_order k=%0d got %0d expected %0d", k,
                 (k < order.size()) ? order[k] : -1, k % NREQ);
      end
      checks++;
    end
  endtask

  task automatic test_full_stall();
    int base;
    do_reset();
    base = wcount;
    for (int w = 0; w < 4; w++) pq[2].push_back(8'hC0 + 8'(w));
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_stall c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (fifo_full && (fifo_wr !== 1'b0 || gnt !== 4'b0100)) begin
        errors++;
        $display("FAIL full_hold c=%0d got wr=%b gnt=%b expected 0/0100", c, fifo_wr, gnt);
      end
      tick();
    end
    fifo_full = 1'b0;
    if (wcount - base !== 4) begin
      errors++;
      $display("FAIL full_count got %0d expected 4", wcount - base);
    end
    checks++;
  endtask

  task automatic test_withdraw();
    do_reset();
    pq[1].push_back(8'h51); pq[1].push_back(8'h52);
    pq[3].push_back(8'h71); pq[3].push_back(8'h72);
    for (int c = 0; c < 7; c++) begin
      mask[1] = (c < 2);
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL withdraw c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if ((c == 3 && gnt !== 4'b0000) || (c == 4 && gnt !== 4'b1000)) begin
        errors++;
        $display("FAIL withdraw_gnt c=%0d got %b expected %b", c, gnt,
                 (c == 3) ? 4'b0000 : 4'b1000);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pq[2].push_back(8'h22);
    for (int c = 0; c < 3; c++) begin
      drive(); settle(); tick();
    end
    for (int i = 1; i < NREQ; i++)
      for (int w = 0; w < 4; w++) pq[i].push_back(8'(8'h80 + i * 16 + w));
    for (int c = 0; c < 3; c++) begin
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL async_pre c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (c < 2) tick();
    end
    // Assert reset between edges while the owner is mid-burst.
    #2;
    rst = 1'b0;
    #1;
    if (obs_vec() !== 18'h0) begin
      errors++;
      $display("FAIL async_clear got %h expected 00000", obs_vec());
    end
    checks++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL async_post c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (c == 1 && gnt !== 4'b0010) begin
        errors++;
        $display("FAIL async_first_gnt got %b expected 0010", gnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NREQ - 1);
        if (pq[p].size() < 6) pq[p].push_back(DW'($urandom));
      end
      for (int i = 0; i < NREQ; i++) mask[i] = ($urandom_range(0, 9) != 0);
      fifo_full = ($urandom_range(0, 4) == 0);
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d req=%b full=%b got %h expected %h",
                 c, req, fifo_full, obs_vec(), exp_vec());
      end
      checks++;
      tick();
    end
    fifo_full = 1'b0;
  endtask

`ifdef FIFO_ARB_PRIO_EN
  task automatic test_prio();
    int order [$];
    int prev;
    do_reset();
    pq[2].push_back(8'h2A);
    for (int c = 0; c < 3; c++) begin
      drive(); settle(); tick();
    end
    pq[0].push_back(8'h01); pq[0].push_back(8'h02);
    pq[3].push_back(8'h31); pq[3].push_back(8'h32);
    prev = -1;
    for (int c = 0; c < 9; c++) begin
      drive();
      settle();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL prio c=%0d got %h expected %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (gnt_idx() >= 0 && prev < 0) order.push_back(gnt_idx());
      prev = gnt_idx();
      tick();
    end
    if (order.size() < 2 || order[0] !== 0 || order[1] !== 3) begin
      errors++;
      $display("FAIL prio_order got %0d,%0d expected 0,3",
               (order.size() > 0) ? order[0] : -1, (order.size() > 1) ? order[1] : -1);
    end
    checks++;
  endtask
`endif

  initial begin
    rst = 1'b0;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    wcount = 0;
    model_reset();
    test_reset();
    test_single();
    test_contend();
    test_full_stall();
    test_withdraw();
    test_async_reset();
`ifdef FIFO_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
